// File: rtl/gbe_tx_ovf_counter.sv
`default_nettype none
// ============================================================================
// Module   : gbe_tx_ovf_counter
// Purpose  : Watches the 10GbE TX FIFO handshake and packs two saturating
//            statistics into the 32-bit word that feeds the TX overflow
//            software register:
//              - ovf_events : rising edges of tx_overflow
//              - bad_frames : frames that lost at least one word to overflow
//            A rising edge on ctr_rst clears both counts and the sticky flag.
// Ports    : user_clk        - sole clock
//            user_rst_n      - asynchronous active-low reset
//            tx_valid        - word enters the TX FIFO this cycle
//            tx_end_of_frame - last word of a frame (qualified by tx_valid)
//            tx_overflow     - TX FIFO dropping words (level)
//            ctr_rst         - software clear request (rising edge acts)
//            user_data_out   - {ovf_events, bad_frames}
//            ovf_sticky      - set by any overflow event, cleared by clear/reset
// Revision : 1.0 - initial release
// ============================================================================
module gbe_tx_ovf_counter #(
  parameter int CNT_W = 16
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic               tx_valid,
  input  logic               tx_end_of_frame,
  input  logic               tx_overflow,
  input  logic               ctr_rst,
  output logic [2*CNT_W-1:0] user_data_out,
  output logic               ovf_sticky
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOOD = 2'd1,
    ST_BAD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             ovf_prev_q;
  logic             clr_prev_q;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic             sticky_q, sticky_d;

  logic w_ovf_edge;
  logic w_clr_edge;
  logic w_eof_acc;
  logic w_bad_frame;

  always_comb begin
    w_ovf_edge  = tx_overflow & ~ovf_prev_q;
    w_clr_edge  = ctr_rst & ~clr_prev_q;
    w_eof_acc   = tx_valid & tx_end_of_frame;
    // A frame is bad if it was already marked, or if overflow coincides with
    // its last word (this also covers single-word frames seen in IDLE).
    w_bad_frame = w_eof_acc & ((state_q == ST_BAD) | tx_overflow);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Overflow seen in IDLE without a word does not taint the next frame.
        if (tx_valid & ~tx_end_of_frame)
          state_d = tx_overflow ? ST_BAD : ST_GOOD;
      end
      ST_GOOD: begin
        if (w_eof_acc)
          state_d = ST_IDLE;
        else if (tx_overflow)
          state_d = ST_BAD;
      end
      ST_BAD: begin
        if (w_eof_acc)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_cnt_d = ovf_cnt_q;
    bad_cnt_d = bad_cnt_q;
    sticky_d  = sticky_q;
    // Clear wins over any same-cycle increment; the FSM is left untouched so
    // a frame already marked bad is still counted when it ends.
    if (w_clr_edge) begin
      ovf_cnt_d = '0;
      bad_cnt_d = '0;
      sticky_d  = 1'b0;
    end else begin
      if (w_ovf_edge) begin
        sticky_d = 1'b1;
        if (ovf_cnt_q != C_CNT_MAX)
          ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
      if (w_bad_frame && (bad_cnt_q != C_CNT_MAX))
        bad_cnt_d = bad_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= ST_IDLE;
      // Previous-value registers reset high so a level already asserted at
      // reset release is not mistaken for an edge.
      ovf_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
      ovf_cnt_q  <= '0;
      bad_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ovf_prev_q <= tx_overflow;
      clr_prev_q <= ctr_rst;
      ovf_cnt_q  <= ovf_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign user_data_out = {ovf_cnt_q, bad_cnt_q};
  assign ovf_sticky    = sticky_q;

endmodule
`default_nettype wire

// File: doc/gbe_tx_ovf_counter.md
# gbe_tx_ovf_counter

Statistics stage that sits directly upstream of the 10GbE TX overflow-counter software register. It watches the 10GbE TX FIFO handshake and produces the 32-bit word that feeds that register's `user_data_in`. The word packs two saturating counts:
- overflow events;
- frames corrupted by an overflow.

Software clears the counts by toggling a control bit.

## Interface
Parameters:
- CNT_W, 16, width of each counter field; `user_data_out` is 2*CNT_W bits.

Ports:
- user_clk, input, 1, sole clock; every signal is synchronous to it.
- user_rst_n, input, 1, reset. Asynchronous assertion, active-low.
- tx_valid, input, 1, a word enters the 10GbE TX FIFO this cycle.
- tx_end_of_frame, input, 1, qualified by tx_valid; marks the last word of a frame.
- tx_overflow, input, 1, level from the 10GbE core: the TX FIFO is dropping words.
- ctr_rst, input, 1, software clear request. Level signal; only its rising edge acts.
- user_data_out, output, 2*CNT_W. [2*CNT_W-1:CNT_W] = ovf_events, [CNT_W-1:0] = bad_frames. Connects to the register's `user_data_in`.
- ovf_sticky, output, 1, set by any overflow event; cleared only by a clear or by reset.

## Operation
- Overflow edge detection:
  - ovf_prev registers tx_overflow.
  - ovf_edge = tx_overflow & ~ovf_prev.
  - A sustained overflow level counts once.
- Clear edge detection: clr_prev registers ctr_rst; clr_edge = ctr_rst & ~clr_prev.
- Frame FSM, states IDLE, GOOD, BAD:
  - IDLE: tx_valid & ~tx_end_of_frame -> GOOD, or BAD if tx_overflow is high that cycle.
  - GOOD: tx_overflow -> BAD.
  - GOOD or BAD: tx_valid & tx_end_of_frame -> IDLE.
  - A frame is counted bad when its end-of-frame word is accepted in BAD, or with tx_overflow high on that same cycle.
  - Single-word frame (tx_valid & tx_end_of_frame in IDLE): counted bad if tx_overflow is high that cycle; the FSM stays in IDLE.
  - tx_overflow in IDLE without tx_valid does not mark the next frame.
- ovf_events:
  - Increments by 1 on ovf_edge.
  - Saturates at 2^CNT_W-1; it never wraps.
- bad_frames: increments by 1 per bad frame, with the same saturation rule.
- Clear (clr_edge):
  - Zeroes both counters and ovf_sticky.
  - Has priority over any increment in the same cycle; that increment is lost.
  - Does not change FSM state, so a frame in progress in BAD is still counted at its end.
- Both counters increment independently; simultaneous events in one cycle each add 1.

## Timing
- Reset values:
  - user_data_out = 0, ovf_sticky = 0, FSM = IDLE.
  - ovf_prev = 1 and clr_prev = 1, so a level already high at reset release is not counted as an edge.
- Latency: a condition sampled at rising edge N is reflected in user_data_out and ovf_sticky immediately after edge N (one register, no combinational path from inputs to outputs).
- Clear: counters read 0 after the edge where the rising ctr_rst is sampled.
- Reset assertion mid-frame: the FSM returns to IDLE and the frame is not counted. The next frame starts fresh on the first tx_valid after release.
- Throughput: one word per cycle, with no stall input and no back-pressure produced.

## Test plan
- Reset, idle 10 cycles -> user_data_out = 0x00000000, ovf_sticky = 0.
- tx_overflow held high for 20 cycles, then low, then high again for 1 cycle -> ovf_events = 2, user_data_out = 0x00020000, ovf_sticky = 1.
- 8-word frame with tx_overflow pulsed at word 3; then a clean 8-word frame; then a 1-word frame with tx_overflow on its only word -> bad_frames = 2, ovf_events = 2, user_data_out = 0x00020002.
- Preload by driving 65537 separate overflow pulses -> ovf_events saturates at 0xFFFF, with no wrap to 0.
- ctr_rst rising on the same cycle as an ovf_edge -> user_data_out = 0 on the next cycle; ctr_rst held high afterwards causes no further clears; a later ovf_edge gives 0x00010000.
- user_rst_n asserted while the FSM is in BAD, released, then a clean 4-word frame -> bad_frames = 0.
